// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, datapath defaults and forward-select encoding
package alu_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_REGBITS = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM
    } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - one execute-stage operand bypass: MEM over WB over register file
module fwd_mux
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS
) (
    input  logic [REGBITS-1:0] src,
    input  logic [WIDTH-1:0]   rf_value,
    input  logic               m_regwrite,
    input  logic [REGBITS-1:0] m_writereg,
    input  logic [WIDTH-1:0]   m_aluout,
    input  logic               w_regwrite,
    input  logic [REGBITS-1:0] w_writereg,
    input  logic [WIDTH-1:0]   w_result,
    output logic [WIDTH-1:0]   value
);

    fwd_sel_t sel;

    // A nonzero writer match excludes $0, so reads of $0 always see the register file.
    always_comb begin
        sel = FWD_RF;
        if (m_regwrite && (m_writereg != '0) && (m_writereg == src)) begin
            sel = FWD_MEM;
        end else if (w_regwrite && (w_writereg != '0) && (w_writereg == src)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        value = rf_value;
        case (sel)
            FWD_MEM: value = m_aluout;
            FWD_WB:  value = w_result;
            default: value = rf_value;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with bypassing and load-use detection ahead of the ALU
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_valid,
    input  logic [WIDTH-1:0]   d_rd1,
    input  logic [WIDTH-1:0]   d_rd2,
    input  logic [WIDTH-1:0]   d_signimm,
    input  logic [REGBITS-1:0] d_rs,
    input  logic [REGBITS-1:0] d_rt,
    input  logic [REGBITS-1:0] d_rd,
    input  logic [2:0]         d_alucontrol,
    input  logic               d_alusrc,
    input  logic               d_regdst,
    input  logic               d_regwrite,
    input  logic               d_memtoreg,
    input  logic               d_memwrite,
    input  logic               stall_in,
    input  logic               flush,
    input  logic               m_regwrite,
    input  logic [REGBITS-1:0] m_writereg,
    input  logic [WIDTH-1:0]   m_aluout,
    input  logic               w_regwrite,
    input  logic [REGBITS-1:0] w_writereg,
    input  logic [WIDTH-1:0]   w_result,
    output logic               load_use_stall,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_control,
    output logic [WIDTH-1:0]   e_writedata,
    output logic [REGBITS-1:0] e_writereg,
    output logic               e_valid,
    output logic               e_regwrite,
    output logic               e_memtoreg,
    output logic               e_memwrite
);

    logic [WIDTH-1:0]   e_rd1;
    logic [WIDTH-1:0]   e_rd2;
    logic [WIDTH-1:0]   e_signimm;
    logic [REGBITS-1:0] e_rs;
    logic [REGBITS-1:0] e_rt;
    logic [REGBITS-1:0] e_rd;
    logic [2:0]         e_alucontrol;
    logic               e_alusrc;
    logic               e_regdst;
    logic [WIDTH-1:0]   fwd_a;
    logic [WIDTH-1:0]   fwd_b;

    assign load_use_stall = e_valid && e_memtoreg && e_regwrite && (e_rt != '0) && d_valid
                            && ((d_rs == e_rt) || (d_rt == e_rt));

    // A bubble is all-zero fields: a nop that the ALU sees as AND of 0 and 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid      <= 1'b0;
            e_rd1        <= '0;
            e_rd2        <= '0;
            e_signimm    <= '0;
            e_rs         <= '0;
            e_rt         <= '0;
            e_rd         <= '0;
            e_alucontrol <= ALU_AND;
            e_alusrc     <= 1'b0;
            e_regdst     <= 1'b0;
            e_regwrite   <= 1'b0;
            e_memtoreg   <= 1'b0;
            e_memwrite   <= 1'b0;
        end else if (flush || (!stall_in && load_use_stall)) begin
            e_valid      <= 1'b0;
            e_rd1        <= '0;
            e_rd2        <= '0;
            e_signimm    <= '0;
            e_rs         <= '0;
            e_rt         <= '0;
            e_rd         <= '0;
            e_alucontrol <= ALU_AND;
            e_alusrc     <= 1'b0;
            e_regdst     <= 1'b0;
            e_regwrite   <= 1'b0;
            e_memtoreg   <= 1'b0;
            e_memwrite   <= 1'b0;
        end else if (!stall_in) begin
            e_valid      <= d_valid;
            e_rd1        <= d_rd1;
            e_rd2        <= d_rd2;
            e_signimm    <= d_signimm;
            e_rs         <= d_rs;
            e_rt         <= d_rt;
            e_rd         <= d_rd;
            e_alucontrol <= d_alucontrol;
            e_alusrc     <= d_alusrc;
            e_regdst     <= d_regdst;
            e_regwrite   <= d_regwrite && d_valid;
            e_memtoreg   <= d_memtoreg;
            e_memwrite   <= d_memwrite && d_valid;
        end
    end

    fwd_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_a (
        .src        (e_rs),
        .rf_value   (e_rd1),
        .m_regwrite (m_regwrite),
        .m_writereg (m_writereg),
        .m_aluout   (m_aluout),
        .w_regwrite (w_regwrite),
        .w_writereg (w_writereg),
        .w_result   (w_result),
        .value      (fwd_a)
    );

    fwd_mux #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_b (
        .src        (e_rt),
        .rf_value   (e_rd2),
        .m_regwrite (m_regwrite),
        .m_writereg (m_writereg),
        .m_aluout   (m_aluout),
        .w_regwrite (w_regwrite),
        .w_writereg (w_writereg),
        .w_result   (w_result),
        .value      (fwd_b)
    );

    assign alu_a       = fwd_a;
    assign alu_b       = e_alusrc ? e_signimm : fwd_b;
    assign e_writedata = fwd_b;
    assign alu_control = e_alucontrol;
    assign e_writereg  = e_regdst ? e_rd : e_rt;

endmodule
